// File: rtl/demux_16w_1_2_q.sv
// demux_16w_1_2_q
//   Steers one valid/ready 16-bit word stream to channel A (Sel=0) or
//   channel B (Sel=1). Each channel has its own 2-entry FIFO, so the two
//   consumers can stall independently of each other.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   In, Sel         producer word and destination (0 = A, 1 = B)
//   InValid         producer has a word on In
//   InReady         selected channel has room (depends only on Sel and the counts)
//   OutA/ValidA     head of FIFO A and its non-empty flag; ReadyA pops it
//   OutB/ValidB     head of FIFO B and its non-empty flag; ReadyB pops it
//   CountA, CountB  FIFO occupancies (0..2)
module demux_16w_1_2_q (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] In,
    input  logic        Sel,
    input  logic        InValid,
    output logic        InReady,
    output logic [15:0] OutA,
    output logic        ValidA,
    input  logic        ReadyA,
    output logic [15:0] OutB,
    output logic        ValidB,
    input  logic        ReadyB,
    output logic [1:0]  CountA,
    output logic [1:0]  CountB
);

    // Index 0 is channel A, index 1 is channel B throughout.
    logic [1:0][1:0][15:0] mem_q, mem_d;
    logic [1:0]            rd_q, rd_d;
    logic [1:0]            wr_q, wr_d;
    logic [1:0][1:0]       cnt_q, cnt_d;

    logic [1:0] ready;
    logic [1:0] valid;
    logic [1:0] push;
    logic [1:0] pop;

    assign ready = {ReadyB, ReadyA};

    always_comb begin
        valid[0] = (cnt_q[0] != 2'd0);
        valid[1] = (cnt_q[1] != 2'd0);
    end

    // A full channel refuses the push even if it pops in the same cycle.
    assign InReady = Sel ? (cnt_q[1] != 2'd2) : (cnt_q[0] != 2'd2);

    assign push[0] = InValid && InReady && !Sel;
    assign push[1] = InValid && InReady && Sel;
    assign pop     = valid & ready;

    always_comb begin
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        for (int c = 0; c < 2; c++) begin
            if (push[c]) begin
                mem_d[c][wr_q[c]] = In;
                wr_d[c]           = ~wr_q[c];
            end
            if (pop[c]) begin
                rd_d[c] = ~rd_q[c];
            end
            unique case ({push[c], pop[c]})
                2'b10:   cnt_d[c] = cnt_q[c] + 2'd1;
                2'b01:   cnt_d[c] = cnt_q[c] - 2'd1;
                default: cnt_d[c] = cnt_q[c];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Outputs come straight from storage; no bypass from In.
    assign OutA   = mem_q[0][rd_q[0]];
    assign OutB   = mem_q[1][rd_q[1]];
    assign ValidA = valid[0];
    assign ValidB = valid[1];
    assign CountA = cnt_q[0];
    assign CountB = cnt_q[1];

endmodule

// File: tb/tb_demux_16w_1_2_q.sv
module tb_demux_16w_1_2_q;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_w;
    logic        sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_a;
    logic        valid_a;
    logic        ready_a;
    logic [15:0] out_b;
    logic        valid_b;
    logic        ready_b;
    logic [1:0]  count_a;
    logic [1:0]  count_b;

    int checks = 0;
    int errors = 0;

    // Reference model: one word queue per channel.
    logic [15:0] qa[$];
    logic [15:0] qb[$];

    demux_16w_1_2_q dut (
        .clk     (clk),
        .rst     (rst),
        .In      (in_w),
        .Sel     (sel),
        .InValid (in_valid),
        .InReady (in_ready),
        .OutA    (out_a),
        .ValidA  (valid_a),
        .ReadyA  (ready_a),
        .OutB    (out_b),
        .ValidB  (valid_b),
        .ReadyB  (ready_b),
        .CountA  (count_a),
        .CountB  (count_b)
    );

    always #5 clk = ~clk;

    // Advance one clock; the model applies the same transfer rules to the
    // inputs that are present just before the edge.
    task automatic step();
        bit acc, pa, pb;
        logic [15:0] w;
        bit s;
        w   = in_w;
        s   = sel;
        acc = in_valid && (s ? (qb.size() < 2) : (qa.size() < 2));
        pa  = ready_a && (qa.size() > 0);
        pb  = ready_b && (qb.size() > 0);
        @(posedge clk);
        #1;
        if (rst) begin
            qa.delete();
            qb.delete();
        end else begin
            if (pa) void'(qa.pop_front());
            if (pb) void'(qb.pop_front());
            if (acc) begin
                if (s) qb.push_back(w);
                else   qa.push_back(w);
            end
        end
    endtask

    task automatic idle_inputs();
        rst      = 1'b0;
        in_w     = 16'h0000;
        sel      = 1'b0;
        in_valid = 1'b0;
        ready_a  = 1'b0;
        ready_b  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        step();
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid_a got %b want 0", valid_a); end
        checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL reset_valid_b got %b want 0", valid_b); end
        checks++; if (out_a !== 16'h0000) begin errors++; $display("FAIL reset_out_a got %h want 0000", out_a); end
        checks++; if (out_b !== 16'h0000) begin errors++; $display("FAIL reset_out_b got %h want 0000", out_b); end
        checks++; if (count_a !== 2'd0) begin errors++; $display("FAIL reset_count_a got %0d want 0", count_a); end
        checks++; if (count_b !== 2'd0) begin errors++; $display("FAIL reset_count_b got %0d want 0", count_b); end
        sel = 1'b0; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_sel0 got %b want 1", in_ready); end
        sel = 1'b1; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_sel1 got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        do_reset();
        in_w = 16'h1234; sel = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL single_valid_a got %b want 1", valid_a); end
        checks++; if (out_a !== 16'h1234) begin errors++; $display("FAIL single_out_a got %h want 1234", out_a); end
        checks++; if (count_a !== 2'd1) begin errors++; $display("FAIL single_count_a got %0d want 1", count_a); end
        checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL single_valid_b got %b want 0", valid_b); end
        ready_a = 1'b1;
        step();
        ready_a = 1'b0;
        checks++; if (count_a !== 2'd0) begin errors++; $display("FAIL single_pop_count_a got %0d want 0", count_a); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL single_pop_valid_a got %b want 0", valid_a); end
    endtask

    // Leaves A = {AAAA, BBBB}, B = {CCCC} for test_full_pop.
    task automatic test_fill();
        do_reset();
        sel = 1'b0; in_valid = 1'b1;
        in_w = 16'hAAAA; step();
        in_w = 16'hBBBB; step();
        in_valid = 1'b0; #1;
        checks++; if (count_a !== 2'd2) begin errors++; $display("FAIL fill_count_a got %0d want 2", count_a); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready_sel0 got %b want 0", in_ready); end
        sel = 1'b1; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_in_ready_sel1 got %b want 1", in_ready); end
        in_w = 16'hCCCC; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (valid_b !== 1'b1) begin errors++; $display("FAIL fill_valid_b got %b want 1", valid_b); end
        checks++; if (out_b !== 16'hCCCC) begin errors++; $display("FAIL fill_out_b got %h want cccc", out_b); end
        checks++; if (out_a !== 16'hAAAA) begin errors++; $display("FAIL fill_out_a got %h want aaaa", out_a); end
        checks++; if (count_a !== 2'd2) begin errors++; $display("FAIL fill_count_a_kept got %0d want 2", count_a); end
    endtask

    task automatic test_full_pop();
        in_w = 16'hDDDD; sel = 1'b0; in_valid = 1'b1; ready_a = 1'b1; #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fullpop_in_ready_before got %b want 0", in_ready); end
        step();
        ready_a = 1'b0; #1;
        checks++; if (count_a !== 2'd1) begin errors++; $display("FAIL fullpop_count_a got %0d want 1", count_a); end
        checks++; if (out_a !== 16'hBBBB) begin errors++; $display("FAIL fullpop_out_a got %h want bbbb", out_a); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fullpop_in_ready_after got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (count_a !== 2'd2) begin errors++; $display("FAIL fullpop_refill_count_a got %0d want 2", count_a); end
        // Drain both channels together and follow the model.
        ready_a = 1'b1; ready_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (valid_a !== (qa.size() != 0) || (qa.size() != 0 && out_a !== qa[0])) begin
                errors++; $display("FAIL drain_a[%0d] got v=%b d=%h want size %0d", i, valid_a, out_a, qa.size());
            end
            step();
        end
        checks++; if (qa.size() != 0 || valid_a !== 1'b0 || valid_b !== 1'b0) begin
            errors++; $display("FAIL drain_empty got va=%b vb=%b want 0 0", valid_a, valid_b);
        end
        ready_a = 1'b0; ready_b = 1'b0;
    endtask

    task automatic test_stream();
        logic [15:0] w;
        do_reset();
        ready_a = 1'b1; ready_b = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            w = 16'(i);
            in_w = w; sel = ((i % 2) == 0); #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got %b want 1", i, in_ready); end
            step();
            checks++;
            if ((i % 2) == 1 ? (valid_a !== 1'b1 || out_a !== w) : (valid_b !== 1'b1 || out_b !== w)) begin
                errors++; $display("FAIL stream_word[%0d] got a=%h/%b b=%h/%b want %h", i, out_a, valid_a, out_b, valid_b, w);
            end
            checks++; if (count_a > 2'd1 || count_b > 2'd1) begin
                errors++; $display("FAIL stream_count[%0d] got %0d/%0d want <=1", i, count_a, count_b);
            end
        end
        in_valid = 1'b0;
        step();
        checks++; if (valid_a !== 1'b0 || valid_b !== 1'b0) begin errors++; $display("FAIL stream_end got %b/%b want 0/0", valid_a, valid_b); end
        ready_a = 1'b0; ready_b = 1'b0;
    endtask

    // Three push/pop pairs on A leave both pointers at entry 1, so the stale
    // head after draining is the second word.
    task automatic test_wrap();
        logic [15:0] w [3];
        w[0] = 16'h1111; w[1] = 16'h2222; w[2] = 16'h3333;
        do_reset();
        ready_a = 1'b1; sel = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_w = w[i];
            step();
            checks++; if (valid_a !== 1'b1 || out_a !== w[i]) begin
                errors++; $display("FAIL wrap_order[%0d] got %h/%b want %h", i, out_a, valid_a, w[i]);
            end
        end
        in_valid = 1'b0;
        step();
        ready_a = 1'b0;
        checks++; if (valid_a !== 1'b0 || out_a !== w[1]) begin
            errors++; $display("FAIL wrap_stale got %h/%b want %h/0", out_a, valid_a, w[1]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 500; i++) begin
            in_w     = 16'($urandom_range(0, 65535));
            sel      = 1'($urandom_range(0, 1));
            in_valid = ($urandom_range(0, 3) != 0);
            ready_a  = ($urandom_range(0, 2) != 0);
            ready_b  = ($urandom_range(0, 2) == 0);
            #1;
            checks++;
            if (in_ready !== (sel ? (qb.size() < 2) : (qa.size() < 2))
                || count_a !== 2'(qa.size()) || count_b !== 2'(qb.size())
                || valid_a !== (qa.size() != 0) || valid_b !== (qb.size() != 0)
                || (qa.size() != 0 && out_a !== qa[0]) || (qb.size() != 0 && out_b !== qb[0])) begin
                errors++;
                $display("FAIL random[%0d] got rdy=%b ca=%0d cb=%0d a=%h b=%h want ca=%0d cb=%0d a=%h b=%h",
                         i, in_ready, count_a, count_b, out_a, out_b, qa.size(), qb.size(),
                         (qa.size() != 0) ? qa[0] : 16'h0, (qb.size() != 0) ? qb[0] : 16'h0);
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        sel = 1'b0; in_valid = 1'b1;
        in_w = 16'h0A0A; step();
        in_w = 16'h0B0B; step();
        sel = 1'b1; in_w = 16'h0C0C; step();
        checks++; if (count_a !== 2'd2 || count_b !== 2'd1) begin
            errors++; $display("FAIL mid_setup got %0d/%0d want 2/1", count_a, count_b);
        end
        rst = 1'b1; in_w = 16'h0D0D; sel = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
        step();
        idle_inputs();
        checks++; if (count_a !== 2'd0 || count_b !== 2'd0) begin errors++; $display("FAIL mid_counts got %0d/%0d want 0/0", count_a, count_b); end
        checks++; if (valid_a !== 1'b0 || valid_b !== 1'b0) begin errors++; $display("FAIL mid_valids got %b/%b want 0/0", valid_a, valid_b); end
        checks++; if (out_a !== 16'h0000 || out_b !== 16'h0000) begin errors++; $display("FAIL mid_outs got %h/%h want 0000/0000", out_a, out_b); end
        step();
        checks++; if (valid_b !== 1'b0 || count_b !== 2'd0) begin errors++; $display("FAIL mid_discard got %b/%0d want 0/0", valid_b, count_b); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_fill();
        test_full_pop();
        test_stream();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
